uart_packet_tx: RTL and testbench



---
 rtl/Structures.sv | 25 ++
 rtl/uart_baud_gen.sv | 29 ++
 rtl/uart_packet_tx.sv | 163 ++++++++++++++++
 tb/tb_uart_packet_tx.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/Structures.sv
// Shared type definitions for the UART packet path: the arbiter byte stream
// and the transmitter state encoding.
package Structures;

    typedef struct packed {
        logic [7:0] Data;
        logic       Valid;
        logic       SoP;
        logic       EoP;
    } UART_PACKET;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GAP
    } UART_TX_STATE;

    // Nearest-integer clock cycles per bit-time.
    function automatic int calcBaudDiv(input int clockFrequency, input int baudRate);
        return (clockFrequency + baudRate / 2) / baudRate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time divider: counts 0..BAUD_DIV-1 and strobes opBitEnd on the terminal count.
// ipRestart reloads the count so every bit period starts with a fresh phase.
module uart_baud_gen #(
    parameter int BAUD_DIV = 434
) (
    input  logic ipClk,
    input  logic ipReset,
    input  logic ipRestart,
    output logic opBitEnd
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] divCnt;

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            divCnt <= '0;
        end else if (ipRestart || (divCnt == LAST)) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + CNT_W'(1);
        end
    end

    assign opBitEnd = (divCnt == LAST);

endmodule

// File: rtl/uart_packet_tx.sv
// 8N1 UART transmitter fed by the packet arbiter over Valid/Ready; inserts an
// optional idle gap after end-of-packet bytes. All outputs are registered.
module uart_packet_tx
    import Structures::*;
#(
    parameter int CLOCK_FREQUENCY = 50_000_000,
    parameter int BAUD_RATE       = 115200,
    parameter int STOP_BITS       = 1,
    parameter int EOP_GAP_BITS    = 0
) (
    input  logic       ipClk,
    input  logic       ipReset,
    input  UART_PACKET ipTxStream,
    output logic       opTxReady,
    output logic       opTx,
    output logic       opBusy
);

    localparam int BAUD_DIV = calcBaudDiv(CLOCK_FREQUENCY, BAUD_RATE);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [3:0] GAP_LAST  = 4'(EOP_GAP_BITS - 1);

    if (BAUD_DIV < 2) begin : gBadBaudDiv
        $error("uart_packet_tx: BAUD_DIV must be at least 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : gBadStopBits
        $error("uart_packet_tx: STOP_BITS must be 1 or 2");
    end
    if ((EOP_GAP_BITS < 0) || (EOP_GAP_BITS > 15)) begin : gBadGapBits
        $error("uart_packet_tx: EOP_GAP_BITS must be 0..15");
    end

    UART_TX_STATE state, stateNext;
    logic [3:0]   bitCnt, bitCntNext;
    logic [7:0]   shiftData, shiftNext;
    logic         eopLatched, eopNext;
    logic         txNext, readyNext, busyNext;
    logic         bitEnd, baudRestart;
    logic [2:0]   nextIdx;
    logic         unusedSoP;

    // Start-of-packet carries no timing meaning for the line.
    assign unusedSoP = ipTxStream.SoP;

    // Divider is held in IDLE and reloaded on every state change.
    assign baudRestart = (state == IDLE) || (stateNext != state);

    uart_baud_gen #(
        .BAUD_DIV(BAUD_DIV)
    ) uBaudGen (
        .ipClk    (ipClk),
        .ipReset  (ipReset),
        .ipRestart(baudRestart),
        .opBitEnd (bitEnd)
    );

    assign nextIdx = bitCnt[2:0] + 3'd1;

    always_comb begin
        stateNext  = state;
        bitCntNext = bitCnt;
        shiftNext  = shiftData;
        eopNext    = eopLatched;
        txNext     = opTx;
        readyNext  = opTxReady;
        busyNext   = opBusy;

        case (state)
            IDLE: begin
                txNext    = 1'b1;
                readyNext = 1'b1;
                busyNext  = 1'b0;
                if (opTxReady && ipTxStream.Valid) begin
                    shiftNext  = ipTxStream.Data;
                    eopNext    = ipTxStream.EoP;
                    stateNext  = START;
                    bitCntNext = '0;
                    txNext     = 1'b0;
                    readyNext  = 1'b0;
                    busyNext   = 1'b1;
                end
            end
            START: begin
                if (bitEnd) begin
                    stateNext  = DATA;
                    bitCntNext = '0;
                    txNext     = shiftData[0];
                end
            end
            DATA: begin
                if (bitEnd) begin
                    if (bitCnt[2:0] == 3'd7) begin
                        stateNext  = STOP;
                        bitCntNext = '0;
                        txNext     = 1'b1;
                    end else begin
                        bitCntNext = bitCnt + 4'd1;
                        txNext     = shiftData[nextIdx];
                    end
                end
            end
            STOP: begin
                if (bitEnd) begin
                    if (bitCnt == STOP_LAST) begin
                        bitCntNext = '0;
                        txNext     = 1'b1;
                        if (eopLatched && (EOP_GAP_BITS > 0)) begin
                            stateNext = GAP;
                        end else begin
                            stateNext = IDLE;
                            readyNext = 1'b1;
                            busyNext  = 1'b0;
                        end
                    end else begin
                        bitCntNext = bitCnt + 4'd1;
                    end
                end
            end
            GAP: begin
                if (bitEnd) begin
                    if (bitCnt == GAP_LAST) begin
                        stateNext  = IDLE;
                        bitCntNext = '0;
                        readyNext  = 1'b1;
                        busyNext   = 1'b0;
                    end else begin
                        bitCntNext = bitCnt + 4'd1;
                    end
                end
            end
            default: begin
                stateNext  = IDLE;
                bitCntNext = '0;
                txNext     = 1'b1;
                readyNext  = 1'b0;
                busyNext   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            state      <= IDLE;
            bitCnt     <= '0;
            eopLatched <= 1'b0;
            opTx       <= 1'b1;
            opTxReady  <= 1'b0;
            opBusy     <= 1'b0;
        end else begin
            state      <= stateNext;
            bitCnt     <= bitCntNext;
            eopLatched <= eopNext;
            opTx       <= txNext;
            opTxReady  <= readyNext;
            opBusy     <= busyNext;
        end
    end

    always_ff @(posedge ipClk) begin
        shiftData <= shiftNext;
    end

endmodule

// File: tb/tb_uart_packet_tx.sv
// Directed bench for uart_packet_tx at 50 MHz / 115200 baud (434 cycles per bit)
// with a 3-bit end-of-packet gap.
module tb_uart_packet_tx;
    import Structures::*;

    localparam int BIT = 434;

    logic       ipClk = 1'b0;
    logic       ipReset;
    UART_PACKET txStream;
    logic       opTxReady;
    logic       opTx;
    logic       opBusy;

    int total = 0;
    int bad   = 0;

    always #5 ipClk = ~ipClk;

    uart_packet_tx #(
        .CLOCK_FREQUENCY(50_000_000),
        .BAUD_RATE      (115200),
        .STOP_BITS      (1),
        .EOP_GAP_BITS   (3)
    ) dut (
        .ipClk     (ipClk),
        .ipReset   (ipReset),
        .ipTxStream(txStream),
        .opTxReady (opTxReady),
        .opTx      (opTx),
        .opBusy    (opBusy)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents one byte at the current negedge (Ready must already be high) and
    // checks every cycle of the frame against the hand-built level list.
    task automatic sendFrame(input logic [7:0] data, input logic eop, input int gapBits,
                             input int pulseAt);
        logic lvl [0:12];
        int   errTx [0:12];
        int   nLvl;
        int   lowCnt;
        int   busyErr;
        nLvl    = 10 + gapBits;
        lowCnt  = 0;
        busyErr = 0;
        lvl[0]  = 1'b0;
        for (int i = 0; i < 8; i++) lvl[i+1] = data[i];
        for (int i = 9; i < 13; i++) lvl[i] = 1'b1;
        for (int i = 0; i < 13; i++) errTx[i] = 0;

        checkVal($sformatf("rdyBefore_%02h", data), {31'd0, opTxReady}, 32'd1);
        txStream.Data  = data;
        txStream.EoP   = eop;
        txStream.SoP   = 1'b1;
        txStream.Valid = 1'b1;
        for (int c = 0; c < nLvl * BIT; c++) begin
            @(negedge ipClk);
            if (c == 0) txStream.Valid = 1'b0;
            if (c == pulseAt) begin
                txStream.Data  = 8'h11;
                txStream.Valid = 1'b1;
            end else if (pulseAt >= 0 && c == pulseAt + 1) begin
                txStream.Valid = 1'b0;
            end
            if (opTx !== lvl[c / BIT]) errTx[c / BIT]++;
            if (opTxReady === 1'b0) lowCnt++;
            if (opBusy !== 1'b1) busyErr++;
        end
        for (int k = 0; k < nLvl; k++) begin
            checkVal($sformatf("tx_%02h_lvl%0d", data, k), errTx[k], 32'd0);
        end
        checkVal($sformatf("rdyLow_%02h", data), lowCnt, nLvl * BIT);
        checkVal($sformatf("busy_%02h", data), busyErr, 32'd0);
        @(negedge ipClk);
        checkVal($sformatf("rdyAfter_%02h", data), {31'd0, opTxReady}, 32'd1);
        checkVal($sformatf("busyAfter_%02h", data), {31'd0, opBusy}, 32'd0);
        checkVal($sformatf("txIdle_%02h", data), {31'd0, opTx}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int errCnt;
        ipReset  = 1'b0;
        txStream = '0;
        txStream.Valid = 1'b1;

        // Reset held with Valid asserted
        repeat (5) begin
            @(negedge ipClk);
            checkVal("rstTx", {31'd0, opTx}, 32'd1);
            checkVal("rstRdy", {31'd0, opTxReady}, 32'd0);
            checkVal("rstBusy", {31'd0, opBusy}, 32'd0);
        end
        ipReset        = 1'b1;
        txStream.Valid = 1'b0;
        @(negedge ipClk);
        checkVal("rdyAfterRst", {31'd0, opTxReady}, 32'd1);

        sendFrame(8'hA5, 1'b0, 0, -1);

        // Back-to-back: second byte offered the cycle Ready returns
        sendFrame(8'h00, 1'b0, 0, -1);
        sendFrame(8'hFF, 1'b0, 0, -1);

        sendFrame(8'h3C, 1'b1, 3, -1);

        // Valid pulse with 0x11 during the data bits must be ignored
        sendFrame(8'h80, 1'b0, 0, 4 * BIT + 100);
        errCnt = 0;
        repeat (500) begin
            @(negedge ipClk);
            if (opTx !== 1'b1 || opBusy !== 1'b0 || opTxReady !== 1'b1) errCnt++;
        end
        checkVal("idleAfterIgnored", errCnt, 32'd0);

        // Asynchronous reset during bit 4 of 0x55
        txStream.Data  = 8'h55;
        txStream.EoP   = 1'b0;
        txStream.Valid = 1'b1;
        errCnt = 0;
        for (int c = 0; c < 5 * BIT + 200; c++) begin
            @(negedge ipClk);
            if (c == 0) txStream.Valid = 1'b0;
            if (c >= 5 * BIT && opTx !== 1'b1) errCnt++;
        end
        checkVal("preAbortBit4", errCnt, 32'd0);
        checkVal("preAbortBusy", {31'd0, opBusy}, 32'd1);
        ipReset = 1'b0;
        #1;
        checkVal("abortTx", {31'd0, opTx}, 32'd1);
        checkVal("abortRdy", {31'd0, opTxReady}, 32'd0);
        checkVal("abortBusy", {31'd0, opBusy}, 32'd0);
        errCnt = 0;
        repeat (3) begin
            @(negedge ipClk);
            if (opTx !== 1'b1 || opTxReady !== 1'b0 || opBusy !== 1'b0) errCnt++;
        end
        checkVal("abortHold", errCnt, 32'd0);
        ipReset = 1'b1;
        @(negedge ipClk);
        checkVal("rdyAfterAbort", {31'd0, opTxReady}, 32'd1);

        sendFrame(8'h01, 1'b0, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
